fp8_normalize_seq: RTL

- Back-end stage of the 8-bit floating-point adder datapath: the other end of the operand-ordering and alignment front end.
- Takes a raw mantissa sum (carry plus fraction) and the larger operand's exponent, and normalizes it iteratively, one shift per clock.
- Packs the result into the 8-bit {exponent, fraction} format and returns it through a valid/ready handshake.
- Sits between the mantissa adder and the result register/display logic.

---
 rtl/fp8_normalize_seq_if.sv | 31 +++
 rtl/fp8_normalize_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/fp8_normalize_seq_if.sv
// ---------------------------------------------------------------------------
// fp8_normalize_seq_if : operand-in / result-out handshake bundle  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface fp8_normalize_seq_if #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W-1:0]       exp_in;
  logic [MAN_W:0]         sum_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W-1:0] result;
  logic                   ovf;
  logic                   unf;

  modport master (
    output in_valid, exp_in, sum_in, out_ready,
    input  in_ready, out_valid, result, ovf, unf
  );

  modport slave (
    input  in_valid, exp_in, sum_in, out_ready,
    output in_ready, out_valid, result, ovf, unf
  );
endinterface

`default_nettype wire

// File: rtl/fp8_normalize_seq.sv
// ---------------------------------------------------------------------------
// fp8_normalize_seq : iterative one-shift-per-clock mantissa normalizer (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fp8_normalize_seq #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fp8_normalize_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [EXP_W-1:0]       exp_reg;
  logic [MAN_W:0]         sum_reg;
  logic [EXP_W+MAN_W-1:0] result_reg;
  logic                   ovf_reg;
  logic                   unf_reg;
  logic                   valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      exp_reg    <= '0;
      sum_reg    <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            exp_reg <= bus.exp_in;
            sum_reg <= bus.sum_in;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
            state   <= NORM;
          end
        end
        NORM: begin
          // Carry can only be set on the first pass; left shifts always refill bit MAN_W with 0.
          if (sum_reg[MAN_W]) begin
            if (exp_reg == '1) begin
              result_reg <= '1;
              ovf_reg    <= 1'b1;
            end else begin
              result_reg <= {exp_reg + EXP_ONE, sum_reg[MAN_W:1]};
            end
            valid_reg <= 1'b1;
            state     <= DONE;
          end else if (sum_reg[MAN_W-1:0] == '0) begin
            result_reg <= '0;
            unf_reg    <= 1'b0;
            valid_reg  <= 1'b1;
            state      <= DONE;
          end else if (sum_reg[MAN_W-1]) begin
            result_reg <= {exp_reg, sum_reg[MAN_W-1:0]};
            valid_reg  <= 1'b1;
            state      <= DONE;
          end else if (exp_reg == '0) begin
            result_reg <= {exp_reg, sum_reg[MAN_W-1:0]};
            unf_reg    <= 1'b1;
            valid_reg  <= 1'b1;
            state      <= DONE;
          end else begin
            sum_reg <= {1'b0, sum_reg[MAN_W-2:0], 1'b0};
            exp_reg <= exp_reg - EXP_ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_reg;
  assign bus.result    = result_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.unf       = unf_reg;

endmodule

`default_nettype wire
